dmem_responder: RTL



---
 rtl/cpu_pkg.sv | 8 +
 rtl/dmem_array.sv | 18 +
 rtl/dmem_responder.sv | 67 ++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM encoding, word width and address check for the data-memory responder
package cpu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  localparam int WORD_W = 32;
  function automatic logic addr_bad(input logic [WORD_W-1:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= WORD_W'(depth));
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM with write enable and registered read
module dmem_array import cpu_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: serialised fixed-latency data-memory target that stalls the pipeline per access
module dmem_responder import cpu_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int LATENCY = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WORD_W-1:0] lat_addr, lat_wdata, cur_addr, cur_wdata, ram_q;
  logic lat_write, cur_write, bad, enter_resp, we, re, rd_zero;
  // With LATENCY==1 the RESP-entry edge is the acceptance edge, so the live request is used
  always_comb begin
    cur_addr = (state == IDLE) ? addr_i : lat_addr;
    cur_wdata = (state == IDLE) ? wdata_i : lat_wdata;
    cur_write = (state == IDLE) ? req_write_i : lat_write;
    bad = addr_bad(cur_addr, DEPTH);
    enter_resp = !rst_i && ((state == IDLE && req_valid_i && LATENCY == 1) || (state == BUSY && cnt == '0));
    we = enter_resp && cur_write && !bad;
    re = enter_resp && !cur_write && !bad;
    stall_o = (state == BUSY) || (state == IDLE && req_valid_i);
    rdata_o = rd_zero ? '0 : ram_q;
  end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk_i(clk_i),
    .we(we),
    .re(re),
    .addr(cur_addr[AW+1:2]),
    .wdata(cur_wdata),
    .rdata(ram_q)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      ack_o <= enter_resp;
      err_o <= enter_resp && bad;
      if (enter_resp && !cur_write) rd_zero <= bad;
      case (state)
        IDLE: if (req_valid_i) begin
          lat_addr <= addr_i;
          lat_wdata <= wdata_i;
          lat_write <= req_write_i;
          cnt <= CW'(LATENCY - 2);
          state <= (LATENCY == 1) ? RESP : BUSY;
        end
        BUSY: if (cnt == '0) state <= RESP; else cnt <= cnt - CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
